pipelined_cla_adder: RTL and testbench
======================================

# pipelined_cla_adder

Parametrised, pipelined carry-lookahead adder/subtractor with a valid/ready handshake on both sides. Operands split into `STAGES` equal slices. Each slice is summed by a multi-group carry-lookahead network, with the carry registered between stages. Sustains one operation per cycle with fixed latency. It is the sequential successor to the team's single-cycle combinational carry-lookahead adder, for datapaths where a full-width lookahead does not close timing.

## Interface
- `WIDTH`, 16: operand/result width in bits.
- `STAGES`, 4: pipeline stages. Must divide `WIDTH`. Slice width `S = WIDTH/STAGES`.
- `BLOCK`, 4: lookahead group width inside a slice. Must divide `S`.
- `i_clk` input 1: clock. Everything is on the rising edge.
- `i_rst` input 1: reset, synchronous, active-high.
- `i_valid` input 1: upstream operation valid.
- `o_ready` output 1: block can accept an operation this cycle.
- `i_add1` input WIDTH: operand A.
- `i_add2` input WIDTH: operand B.
- `i_cin` input 1: carry-in. Used in add mode only.
- `i_sub` input 1: 0 = A+B+cin, 1 = A−B.
- `o_valid` output 1: result valid.
- `i_ready` input 1: downstream accepts the result.
- `o_result` output WIDTH: sum/difference, modulo 2^WIDTH.
- `o_carry` output 1: carry out of the MSB. In sub mode, 1 means no borrow.
- `o_overflow` output 1: two's-complement signed overflow.

## Operation
- Sub mode computes A + ~B + 1. `i_cin` is ignored when `i_sub` = 1.
- Stage k (0..STAGES−1) sums bits [k·S +: S] using the carry registered out of stage k−1. Stage 0 uses the effective carry-in.
- Skew registers delay the upper operand slices so each slice arrives at its stage on the correct cycle.
- Deskew registers delay the lower result slices so all slices emerge together.
- Within a slice, the lookahead works in two levels:
  - Each BLOCK-bit group produces g/p.
  - Group carries are computed by lookahead across the groups; there is no ripple between groups.
- `o_overflow` = (carry into MSB) XOR (carry out of MSB), computed in the last stage.
- Pipeline control is a global stall:
  - `advance = i_ready | ~o_valid`.
  - `o_ready = advance`.
  - An operation is accepted when `i_valid & o_ready`.
  - When `advance` = 0, every stage register holds.
  - Bubbles are not squeezed out.
- Per-stage valid bits travel with the data. Stage registers for invalid entries may update freely, but `o_result`/`o_carry`/`o_overflow` must be held stable whenever `o_valid & ~i_ready`.
- Operations complete strictly in acceptance order. There is no reordering, duplication or loss.

## Timing
- Latency is exactly STAGES cycles from the accept edge to `o_valid` = 1, provided there is no stall.
  - STAGES = 1 gives a registered output after 1 cycle.
- Throughput is 1 operation/cycle while `i_ready` stays high.
- Each stall cycle (`o_valid & ~i_ready`) adds exactly one cycle to every in-flight operation.
- Reset values:
  - `o_valid` = 0, `o_result` = 0, `o_carry` = 0, `o_overflow` = 0.
  - All internal valid bits = 0 and all skew/deskew/carry registers = 0.
  - `o_ready` = 1 in the first cycle after reset releases.
- Reset mid-operation discards all in-flight operations. No stale result may appear after release.
- Reset takes priority over `i_valid`/`i_ready` in the same cycle.
- Simultaneous accept and retire with a full pipe is legal. It must sustain 1/cycle with no bubble inserted.
- Wrap-around: 0xFFFF+1 (WIDTH 16) gives result 0, carry 1. It is not an error.

## Structure
- Package `cla_pkg` holds:
  - the `cla_gp_t` struct (generate/propagate pair);
  - the `gp_combine` function;
  - elaboration checks (`WIDTH % STAGES == 0`, `(WIDTH/STAGES) % BLOCK == 0`, `STAGES ≥ 1`).
- Sub-module `cla_block` is a combinational lookahead group, parametrised by `BLOCK`, with inputs a, b, cin and outputs sum, group g, group p. It is instantiated (S/BLOCK)·STAGES times by generate.
- The top level owns the skew/deskew shift registers, the inter-stage carry and valid registers, and the handshake logic.

## Test plan
- Configuration WIDTH 16, STAGES 4, BLOCK 2, `i_ready` = 1. Apply add 0xFFFF + 0x0001 with cin 0. Exactly 4 cycles after accept, require result 0x0000, carry 1, overflow 0.
- Sub 0x8000 − 0x0001. Require result 0x7FFF, carry 1, overflow 1. Then sub 0x0003 − 0x0005. Require 0xFFFE, carry 0, overflow 0.
- Add 0x7FFF + 0x0000 with cin 1. Require 0x8000, carry 0, overflow 1.
- Stream 64 back-to-back mixed operations. Require one result per cycle, in acceptance order, matching a behavioural A±B model.
- Backpressure: with the pipe full, hold `i_ready` low for 3 cycles. Require:
  - `o_valid` held and outputs stable;
  - `o_ready` = 0 for those cycles;
  - after release, all in-flight results emerge in order with none lost or duplicated.
- Reset with 3 operations in flight:
  - next cycle `o_valid` = 0 and all outputs 0;
  - no stale results afterwards.
  - Also run an exhaustive sweep at WIDTH 4, STAGES 2, BLOCK 2: all A, B, cin, sub combinations (1024 operations), zero mismatches.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  // Generate/propagate pair for a bit or a group of bits.
  typedef struct packed {
    logic g;
    logic p;
  } cla_gp_t;

  // Merge a more-significant span (hi) with the span directly below it (lo).
  function automatic cla_gp_t gp_combine(input cla_gp_t hi, input cla_gp_t lo);
    cla_gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

  // Legal geometry: at least one stage, stages divide width, groups divide a slice.
  function automatic bit cfg_ok(input int width, input int stages, input int block);
    if (stages < 1 || block < 1) return 1'b0;
    if ((width % stages) != 0) return 1'b0;
    return ((width / stages) % block) == 0;
  endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit lookahead group: local sum plus group generate/propagate.
module cla_block
  import cla_pkg::*;
#(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             g,
  output logic             p
);

  logic [BLOCK-1:0] bit_g;
  logic [BLOCK-1:0] bit_p;
  logic [BLOCK-1:0] carry;

  // Group g/p depend only on the operands, never on cin, so the
  // slice-level lookahead that feeds cin back in forms no loop.
  always_comb begin
    cla_gp_t acc;
    bit_g = a & b;
    bit_p = a ^ b;
    acc   = cla_gp_t'{g: 1'b0, p: 1'b1};
    for (int unsigned i = 0; i < BLOCK; i++) begin
      acc = gp_combine(cla_gp_t'{g: bit_g[i], p: bit_p[i]}, acc);
    end
    g = acc.g;
    p = acc.p;
  end

  // Per-bit carries from the prefix of lower bits, then the sum bits.
  always_comb begin
    cla_gp_t acc;
    acc      = cla_gp_t'{g: 1'b0, p: 1'b1};
    carry    = '0;
    carry[0] = cin;
    for (int unsigned i = 1; i < BLOCK; i++) begin
      acc      = gp_combine(cla_gp_t'{g: bit_g[i-1], p: bit_p[i-1]}, acc);
      carry[i] = acc.g | (acc.p & cin);
    end
    sum = bit_p ^ carry;
  end

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one slice per stage, global-stall handshake.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4,
  parameter int BLOCK  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_add1,
  input  logic [WIDTH-1:0] i_add2,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int S  = WIDTH / STAGES;
  localparam int NG = S / BLOCK;

  if (!cfg_ok(WIDTH, STAGES, BLOCK)) begin : g_cfg_check
    $error("pipelined_cla_adder: STAGES must divide WIDTH and BLOCK must divide WIDTH/STAGES");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Stage registers. a_q/b_q hold the not-yet-consumed operand slices
  // (skew), r_q collects finished slices from the top down (deskew).
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] r_q [STAGES];
  logic             c_q [STAGES];
  logic             v_q [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] a_src [STAGES];
  logic [WIDTH-1:0] b_src [STAGES];
  logic [WIDTH-1:0] r_src [STAGES];
  logic             c_src [STAGES];
  logic [WIDTH-1:0] r_nxt [STAGES];
  logic [S-1:0]     sum_st [STAGES];
  logic             cout_st [STAGES];
  logic             cmsb;

  assign advance = i_ready | ~o_valid;
  assign o_ready = advance;

  // Subtraction is A + ~B + 1; carry-in is forced high and i_cin ignored.
  always_comb begin
    b_eff   = i_sub ? ~i_add2 : i_add2;
    cin_eff = i_sub | i_cin;
  end

  // Stage inputs: stage 0 reads the ports, later stages read the previous register.
  always_comb begin
    a_src[0] = i_add1;
    b_src[0] = b_eff;
    r_src[0] = '0;
    c_src[0] = cin_eff;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      r_src[k] = r_q[k-1];
      c_src[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [S-1:0]  sa;
    logic [S-1:0]  sb;
    logic [S-1:0]  sum;
    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG:0]   grp_c;

    assign sa = a_src[k][S-1:0];
    assign sb = b_src[k][S-1:0];

    for (genvar j = 0; j < NG; j++) begin : g_grp
      cla_block #(.BLOCK(BLOCK)) u_blk (
        .a   (sa[j*BLOCK +: BLOCK]),
        .b   (sb[j*BLOCK +: BLOCK]),
        .cin (grp_c[j]),
        .sum (sum[j*BLOCK +: BLOCK]),
        .g   (grp_g[j]),
        .p   (grp_p[j])
      );
    end

    // Group carries: each one is the prefix g/p of all lower groups applied to the slice carry-in.
    always_comb begin
      cla_gp_t acc;
      acc      = cla_gp_t'{g: 1'b0, p: 1'b1};
      grp_c    = '0;
      grp_c[0] = c_src[k];
      for (int unsigned j = 0; j < NG; j++) begin
        acc        = gp_combine(cla_gp_t'{g: grp_g[j], p: grp_p[j]}, acc);
        grp_c[j+1] = acc.g | (acc.p & c_src[k]);
      end
    end

    assign sum_st[k]  = sum;
    assign cout_st[k] = grp_c[NG];
  end

  // Deskew: shift finished slices down and insert this stage's slice at the top;
  // after the last stage slice 0 has reached bit 0.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      r_nxt[k] = r_src[k] >> S;
      r_nxt[k][WIDTH-1 -: S] = sum_st[k];
    end
  end

  // Carry into the MSB recovered from the last stage's top sum bit and its operands.
  assign cmsb = sum_st[STAGES-1][S-1] ^ a_src[STAGES-1][S-1] ^ b_src[STAGES-1][S-1];

  // Pipeline registers: cleared on reset, frozen as a whole while the output is stalled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
        c_q[k] <= 1'b0;
        v_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (advance) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= a_src[k] >> S;
        b_q[k] <= b_src[k] >> S;
        r_q[k] <= r_nxt[k];
        c_q[k] <= cout_st[k];
      end
      v_q[0] <= i_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
        v_q[k] <= v_q[k-1];
      end
      ovf_q <= cmsb ^ cout_st[STAGES-1];
    end
  end

  assign o_valid    = v_q[STAGES-1];
  assign o_result   = r_q[STAGES-1];
  assign o_carry    = c_q[STAGES-1];
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench: 16/4/2 adder for directed, stream, stall and reset cases; 4/2/2 adder swept exhaustively.
module tb_pipelined_cla_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        v16, rdy16, cin16, sub16, ov16, ir16, car16, ovf16;
  logic [15:0] a16, b16, res16;
  logic        v4, rdy4, cin4, sub4, ov4, ir4, car4, ovf4;
  logic [3:0]  a4, b4, res4;

  pipelined_cla_adder #(.WIDTH(16), .STAGES(4), .BLOCK(2)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_valid(v16), .o_ready(rdy16),
    .i_add1(a16), .i_add2(b16), .i_cin(cin16), .i_sub(sub16),
    .o_valid(ov16), .i_ready(ir16), .o_result(res16),
    .o_carry(car16), .o_overflow(ovf16)
  );

  pipelined_cla_adder #(.WIDTH(4), .STAGES(2), .BLOCK(2)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(rdy4),
    .i_add1(a4), .i_add2(b4), .i_cin(cin4), .i_sub(sub4),
    .o_valid(ov4), .i_ready(ir4), .o_result(res4),
    .o_carry(car4), .o_overflow(ovf4)
  );

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        o;
    int unsigned cyc;
    int unsigned stl;
  } exp_t;

  exp_t q16[$];
  exp_t q4[$];
  exp_t e16, e4;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned stalls16 = 0;
  int unsigned last_acc16 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: plain modular arithmetic; carry is "no unsigned wrap" for add,
  // "A >= B" for sub; overflow is the true signed result leaving the range.
  function automatic logic [17:0] model(input int w, input int unsigned a, input int unsigned b,
                                        input bit cin, input bit sub);
    int unsigned mask = (1 << w) - 1;
    int unsigned half = 1 << (w - 1);
    int          sa   = (a >= half) ? int'(a) - (1 << w) : int'(a);
    int          sb   = (b >= half) ? int'(b) - (1 << w) : int'(b);
    int unsigned raw;
    int          sv;
    logic        c, o;
    if (sub) begin
      raw = (a - b) & mask;
      c   = (a >= b);
      sv  = sa - sb;
    end else begin
      raw = a + b + cin;
      c   = raw > mask;
      raw = raw & mask;
      sv  = sa + sb + int'(cin);
    end
    o = (sv > int'(half) - 1) || (sv < -int'(half));
    return {o, c, raw[15:0]};
  endfunction

  task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                         input logic [15:0] er, input logic ec, input logic eo);
    int   n;
    exp_t e;
    @(posedge clk); #1;
    v16 = 1'b1; a16 = a; b16 = b; cin16 = cin; sub16 = sub;
    @(negedge clk);
    n = 0;
    while (rdy16 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rdy16 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept16 timeout o_ready=%b want 1", rdy16);
    end else begin
      e.r = er; e.c = ec; e.o = eo; e.cyc = cyc; e.stl = stalls16;
      q16.push_back(e);
      last_acc16 = cyc;
    end
  endtask

  task automatic send16(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
    logic [17:0] m;
    m = model(16, a, b, cin, sub);
    issue16(a, b, cin, sub, m[15:0], m[16], m[17]);
  endtask

  task automatic send16_rand();
    send16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic cin, input logic sub);
    int          n;
    exp_t        e;
    logic [17:0] m;
    m = model(4, a, b, cin, sub);
    @(posedge clk); #1;
    v4 = 1'b1; a4 = a; b4 = b; cin4 = cin; sub4 = sub;
    @(negedge clk);
    n = 0;
    while (rdy4 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (rdy4 !== 1'b1) begin
      checks++; errors++;
      $display("FAIL accept4 timeout o_ready=%b want 1", rdy4);
    end else begin
      e.r = m[15:0]; e.c = m[16]; e.o = m[17]; e.cyc = cyc; e.stl = 0;
      q4.push_back(e);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    v16 = 1'b0;
    v4  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q16.size() != 0 || q4.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q16.size() != 0 || q4.size() != 0) begin
      errors++;
      $display("FAIL drain pending16=%0d pending4=%0d want 0", q16.size(), q4.size());
    end
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (ov16 !== 1'b0 || res16 !== 16'h0 || car16 !== 1'b0 || ovf16 !== 1'b0 ||
        ov4 !== 1'b0 || res4 !== 4'h0 || car4 !== 1'b0 || ovf4 !== 1'b0) begin
      errors++;
      $display("FAIL %s got v16=%b r16=%h c16=%b o16=%b v4=%b r4=%h c4=%b o4=%b want all 0",
               name, ov16, res16, car16, ovf16, ov4, res4, car4, ovf4);
    end
  endtask

  // 16-bit monitor: handshake rule, hold-under-stall, in-order data and latency.
  logic        prev_stall = 1'b0;
  logic [15:0] hold_r;
  logic        hold_c, hold_o;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      checks++;
      if (rdy16 !== (ir16 | ~ov16)) begin
        errors++;
        $display("FAIL ready16 got %b want %b cycle %0d", rdy16, ir16 | ~ov16, cyc);
      end
      if (prev_stall) begin
        checks++;
        if (ov16 !== 1'b1 || res16 !== hold_r || car16 !== hold_c || ovf16 !== hold_o) begin
          errors++;
          $display("FAIL stall_hold got v=%b r=%h c=%b o=%b want v=1 r=%h c=%b o=%b",
                   ov16, res16, car16, ovf16, hold_r, hold_c, hold_o);
        end
      end
      if (ov16 === 1'b1 && ir16 === 1'b1) begin
        checks++;
        if (q16.size() == 0) begin
          errors++;
          $display("FAIL unexpected16 got result %h with no operation outstanding", res16);
        end else begin
          e16 = q16.pop_front();
          if (res16 !== e16.r || car16 !== e16.c || ovf16 !== e16.o) begin
            errors++;
            $display("FAIL data16 got r=%h c=%b o=%b want r=%h c=%b o=%b",
                     res16, car16, ovf16, e16.r, e16.c, e16.o);
          end
          checks++;
          if (cyc - e16.cyc != 4 + (stalls16 - e16.stl)) begin
            errors++;
            $display("FAIL latency16 got %0d want %0d", cyc - e16.cyc, 4 + (stalls16 - e16.stl));
          end
        end
      end
      prev_stall = ov16 & ~ir16;
      if (prev_stall) begin
        stalls16++;
        hold_r = res16;
        hold_c = car16;
        hold_o = ovf16;
      end
    end
  end

  // 4-bit monitor: in-order data and fixed two-cycle latency.
  always @(negedge clk) begin
    if (!rst && ov4 === 1'b1 && ir4 === 1'b1) begin
      checks++;
      if (q4.size() == 0) begin
        errors++;
        $display("FAIL unexpected4 got result %h with no operation outstanding", res4);
      end else begin
        e4 = q4.pop_front();
        if (res4 !== e4.r[3:0] || car4 !== e4.c || ovf4 !== e4.o) begin
          errors++;
          $display("FAIL data4 got r=%h c=%b o=%b want r=%h c=%b o=%b",
                   res4, car4, ovf4, e4.r[3:0], e4.c, e4.o);
        end
        checks++;
        if (cyc - e4.cyc != 2) begin
          errors++;
          $display("FAIL latency4 got %0d want 2", cyc - e4.cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, pending16=%0d pending4=%0d", q16.size(), q4.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned first_acc;
    int          seen;

    rst = 1'b1;
    v16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0; sub16 = 1'b0; ir16 = 1'b1;
    v4  = 1'b0; a4  = '0; b4  = '0; cin4  = 1'b0; sub4  = 1'b0; ir4  = 1'b1;

    @(posedge clk);
    @(negedge clk);
    check_zero("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_zero("after_release");
    checks++;
    if (rdy16 !== 1'b1 || rdy4 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset got %b/%b want 1/1", rdy16, rdy4);
    end

    // Directed corner cases with hand-derived results.
    issue16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue16(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    issue16(16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    issue16(16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    issue16(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    idle();
    drain();

    // 64 back-to-back random operations must be accepted on consecutive cycles.
    first_acc = 0;
    for (int i = 0; i < 64; i++) begin
      send16_rand();
      if (i == 0) first_acc = last_acc16;
    end
    checks++;
    if (last_acc16 - first_acc != 63) begin
      errors++;
      $display("FAIL stream_rate got %0d cycles for 64 accepts want 63", last_acc16 - first_acc);
    end
    idle();
    drain();

    // Backpressure: drop i_ready for 3 cycles once the pipe is full.
    fork
      begin
        for (int i = 0; i < 16; i++) send16_rand();
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1 ir16 = 1'b0;
        repeat (3) @(posedge clk);
        #1 ir16 = 1'b1;
      end
    join
    drain();
    checks++;
    if (stalls16 != 3) begin
      errors++;
      $display("FAIL stall_count got %0d want 3", stalls16);
    end

    // Reset with three operations in flight; i_valid held high to show reset wins.
    for (int i = 0; i < 3; i++) send16_rand();
    @(posedge clk); #1;
    rst = 1'b1;
    v16 = 1'b1;
    a16 = 16'($urandom);
    q16.delete();
    @(posedge clk);
    @(negedge clk);
    check_zero("reset_flush");
    @(posedge clk); #1;
    rst = 1'b0;
    v16 = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy16 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_flush got %b want 1", rdy16);
    end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (ov16 !== 1'b0) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL stale_after_reset got %0d valid cycles want 0", seen);
    end

    // Exhaustive sweep of the 4-bit configuration.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < 2; s++)
            send4(4'(a), 4'(b), 1'(c), 1'(s));
    idle();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
